// File: rtl/cam_multiport_valid.sv
// cam_multiport_valid: multi-port tag CAM with per-entry valid bits, 1-cycle registered search; define CAM_WR_BYPASS_EN to let a search see same-cycle updates
module cam_multiport_valid #(
  parameter int CAM_DEPTH = 16,
  parameter int CAM_INDEX = 4,
  parameter int CAM_WIDTH = 8,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [CAM_DEPTH-1:0]          inval_mask_i,
  input  logic [NUM_RD-1:0]             search_valid_i,
  input  logic [NUM_RD*CAM_WIDTH-1:0]   tag_i,
  input  logic [NUM_WR-1:0]             we_i,
  input  logic [NUM_WR*CAM_INDEX-1:0]   addr_wr_i,
  input  logic [NUM_WR*CAM_WIDTH-1:0]   tag_wr_i,
  output logic [NUM_RD*CAM_DEPTH-1:0]   match_o,
  output logic [NUM_RD-1:0]             hit_o,
  output logic [NUM_RD*CAM_INDEX-1:0]   hit_idx_o
);
  logic [CAM_WIDTH-1:0] tag_q [CAM_DEPTH];
  logic [CAM_WIDTH-1:0] tag_d [CAM_DEPTH];
  logic [CAM_WIDTH-1:0] cmp_tag [CAM_DEPTH];
  logic [CAM_DEPTH-1:0] valid_q, valid_d, cmp_valid;
  logic [NUM_RD*CAM_DEPTH-1:0] match_d;
  logic [NUM_RD-1:0] hit_d;
  logic [NUM_RD*CAM_INDEX-1:0] idx_d;
  // next entry state: flush beats writes, writes beat invalidates, later write ports override earlier ones
  always_comb begin
    tag_d = tag_q;
    valid_d = flush_i ? '0 : valid_q & ~inval_mask_i;
    for (int w = 0; w < NUM_WR; w++)
      if (we_i[w] && !flush_i) begin
        tag_d[addr_wr_i[w*CAM_INDEX +: CAM_INDEX]] = tag_wr_i[w*CAM_WIDTH +: CAM_WIDTH];
        valid_d[addr_wr_i[w*CAM_INDEX +: CAM_INDEX]] = 1'b1;
      end
  end
  // searches see either the post-update state (bypass) or the registered state
  always_comb begin
`ifdef CAM_WR_BYPASS_EN
    cmp_tag = tag_d;
    cmp_valid = valid_d;
`else
    cmp_tag = tag_q;
    cmp_valid = valid_q;
`endif
  end
  // compare every port against every entry, then priority-encode the lowest match
  always_comb begin
    match_d = '0;
    hit_d = '0;
    idx_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int e = 0; e < CAM_DEPTH; e++)
        match_d[p*CAM_DEPTH+e] = search_valid_i[p] & cmp_valid[e] & (cmp_tag[e] == tag_i[p*CAM_WIDTH +: CAM_WIDTH]);
      hit_d[p] = |match_d[p*CAM_DEPTH +: CAM_DEPTH];
      for (int e = CAM_DEPTH-1; e >= 0; e--)
        if (match_d[p*CAM_DEPTH+e]) idx_d[p*CAM_INDEX +: CAM_INDEX] = CAM_INDEX'(e);
    end
  end
  // entry storage and registered search results
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < CAM_DEPTH; e++) tag_q[e] <= '0;
      valid_q <= '0;
      match_o <= '0;
      hit_o <= '0;
      hit_idx_o <= '0;
    end else begin
      tag_q <= tag_d;
      valid_q <= valid_d;
      match_o <= match_d;
      hit_o <= hit_d;
      hit_idx_o <= idx_d;
    end
  end
endmodule

// File: tb/tb_cam_multiport_valid.sv
// tb_cam_multiport_valid: directed test-plan cases plus random traffic against an entry-array reference model
module tb_cam_multiport_valid;
  localparam int D = 16, I = 4, W = 8, R = 4, NW = 4;
`ifdef CAM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, reset = 1, flush_i = 0;
  logic [D-1:0] inval_mask_i = '0;
  logic [R-1:0] search_valid_i = '0;
  logic [R*W-1:0] tag_i = '0;
  logic [NW-1:0] we_i = '0;
  logic [NW*I-1:0] addr_wr_i = '0;
  logic [NW*W-1:0] tag_wr_i = '0;
  logic [R*D-1:0] match_o;
  logic [R-1:0] hit_o;
  logic [R*I-1:0] hit_idx_o;
  int total = 0, bad = 0;
  logic [W-1:0] mtag [D];
  bit mval [D];

  cam_multiport_valid dut (.clk(clk), .reset(reset), .flush_i(flush_i), .inval_mask_i(inval_mask_i),
    .search_valid_i(search_valid_i), .tag_i(tag_i), .we_i(we_i), .addr_wr_i(addr_wr_i),
    .tag_wr_i(tag_wr_i), .match_o(match_o), .hit_o(hit_o), .hit_idx_o(hit_idx_o));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    reset = 0; flush_i = 0; inval_mask_i = '0; search_valid_i = '0;
    tag_i = '0; we_i = '0; addr_wr_i = '0; tag_wr_i = '0;
  endtask

  task automatic srch(input int p, input logic [W-1:0] t);
    search_valid_i[p] = 1'b1;
    tag_i[p*W +: W] = t;
  endtask

  task automatic wr(input int w, input logic [I-1:0] a, input logic [W-1:0] t);
    we_i[w] = 1'b1;
    addr_wr_i[w*I +: I] = a;
    tag_wr_i[w*W +: W] = t;
  endtask

  task automatic tick();
    logic [W-1:0] nt [D];
    bit nv [D];
    logic [D-1:0] em [R];
    logic [R-1:0] eh;
    logic [I-1:0] ei [R];
    bool_found: begin end
    nt = mtag;
    nv = mval;
    if (reset) begin
      for (int e = 0; e < D; e++) begin nt[e] = '0; nv[e] = 0; end
    end else if (flush_i) begin
      for (int e = 0; e < D; e++) nv[e] = 0;
    end else begin
      for (int e = 0; e < D; e++) if (inval_mask_i[e]) nv[e] = 0;
      for (int w = 0; w < NW; w++)
        if (we_i[w]) begin
          nt[addr_wr_i[w*I +: I]] = tag_wr_i[w*W +: W];
          nv[addr_wr_i[w*I +: I]] = 1;
        end
    end
    eh = '0;
    for (int p = 0; p < R; p++) begin
      bit found;
      em[p] = '0;
      ei[p] = '0;
      found = 0;
      if (!reset && search_valid_i[p])
        for (int e = 0; e < D; e++)
          if (BYP ? (nv[e] && nt[e] == tag_i[p*W +: W]) : (mval[e] && mtag[e] == tag_i[p*W +: W])) begin
            em[p][e] = 1'b1;
            eh[p] = 1'b1;
            if (!found) begin ei[p] = I'(e); found = 1; end
          end
    end
    @(posedge clk);
    mtag = nt;
    mval = nv;
    #1;
    for (int p = 0; p < R; p++) begin
      check($sformatf("match%0d", p), 32'(match_o[p*D +: D]), 32'(em[p]));
      check($sformatf("hit%0d", p), 32'(hit_o[p]), 32'(eh[p]));
      check($sformatf("idx%0d", p), 32'(hit_idx_o[p*I +: I]), 32'(ei[p]));
    end
  endtask

  initial begin
    for (int e = 0; e < D; e++) begin mtag[e] = '0; mval[e] = 0; end
    clr(); reset = 1; tick(); tick();
    clr(); for (int p = 0; p < R; p++) srch(p, 8'h00); tick();
    check("zero_tag_all", match_o, 0);
    check("zero_tag_hit", 32'(hit_o), 0);
    clr(); wr(0, 4'd3, 8'h5A); tick();
    clr(); srch(2, 8'h5A); tick();
    check("p2_match_5a", 32'(match_o[2*D +: D]), 32'h0008);
    check("p2_hit_5a", 32'(hit_o[2]), 1);
    check("p2_idx_5a", 32'(hit_idx_o[2*I +: I]), 3);
    clr(); wr(0, 4'd7, 8'h11); wr(3, 4'd7, 8'h22); tick();
    clr(); srch(0, 8'h11); srch(1, 8'h22); tick();
    check("ww_loser_miss", 32'(hit_o[0]), 0);
    check("ww_winner_hit", 32'(hit_o[1]), 1);
    check("ww_winner_idx", 32'(hit_idx_o[1*I +: I]), 7);
    clr(); wr(1, 4'd2, 8'h33); wr(2, 4'd9, 8'h33); tick();
    clr(); srch(3, 8'h33); tick();
    check("dup_match", 32'(match_o[3*D +: D]), 32'h0204);
    check("dup_idx", 32'(hit_idx_o[3*I +: I]), 2);
    clr(); inval_mask_i = 16'h0004; tick();
    clr(); srch(3, 8'h33); tick();
    check("inval_match", 32'(match_o[3*D +: D]), 32'h0200);
    check("inval_idx", 32'(hit_idx_o[3*I +: I]), 9);
    clr(); wr(0, 4'd5, 8'h44); srch(1, 8'h44); tick();
    check("bypass_hit", 32'(hit_o[1]), 32'(BYP));
    clr(); flush_i = 1; wr(2, 4'd1, 8'h66); for (int p = 0; p < R; p++) srch(p, 8'h33); tick();
    clr(); srch(0, 8'h33); srch(1, 8'h44); srch(2, 8'h66); srch(3, 8'h22); tick();
    check("post_flush_hit", 32'(hit_o), 0);
    clr(); wr(0, 4'd4, 8'h77); tick();
    clr(); srch(0, 8'h77); reset = 1; tick();
    check("reset_discard", 32'(hit_o), 0);
    clr(); srch(0, 8'h77); tick();
    check("reset_cleared", 32'(hit_o), 0);
    repeat (400) begin
      clr();
      reset = ($urandom_range(0, 99) == 0);
      flush_i = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) inval_mask_i = D'($urandom & $urandom & $urandom);
      for (int w = 0; w < NW; w++) if ($urandom_range(0, 1) == 1) wr(w, I'($urandom), W'($urandom_range(0, 7)));
      for (int p = 0; p < R; p++) if ($urandom_range(0, 3) != 0) srch(p, W'($urandom_range(0, 7)));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cam_multiport_valid.md
# cam_multiport_valid

Parametrised multi-port content-addressable memory for issue-queue wakeup and load/store disambiguation tag matching. It has NUM_RD search ports and NUM_WR write ports, plus a per-entry valid bit. Bulk invalidate and flush clear entries. Each search port returns a registered match vector, a hit flag and the lowest matching index. It replaces the fixed 4R4W CAM in new core configurations.

## Interface
- CAM_DEPTH, 16, number of entries
- CAM_INDEX, 4, log2(CAM_DEPTH), width of write address and hit index
- CAM_WIDTH, 8, tag width
- NUM_RD, 4, number of search ports
- NUM_WR, 4, number of write ports
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush_i  in  1  invalidate every entry at the next edge
- inval_mask_i  in  CAM_DEPTH  per-entry invalidate request
- search_valid_i  in  NUM_RD  per-port search request
- tag_i  in  NUM_RD*CAM_WIDTH  search tags; port p occupies bits [p*CAM_WIDTH +: CAM_WIDTH]
- we_i  in  NUM_WR  per-port write enable
- addr_wr_i  in  NUM_WR*CAM_INDEX  write addresses, packed as for tag_i
- tag_wr_i  in  NUM_WR*CAM_WIDTH  write tags
- match_o  out  NUM_RD*CAM_DEPTH  registered match vectors; port p occupies [p*CAM_DEPTH +: CAM_DEPTH]
- hit_o  out  NUM_RD  registered OR of the port's match vector
- hit_idx_o  out  NUM_RD*CAM_INDEX  registered lowest set index of the port's match vector; 0 when no hit

## Operation
- Storage: CAM_DEPTH entries, each holding a CAM_WIDTH-bit tag and a valid bit.
- An entry matches port p only when it is valid, search_valid_i[p]=1, and its stored tag equals tag_i[p]. An invalid entry never matches, even when its stored tag equals the search tag.
- Write: when we_i[w]=1, entry addr_wr_i[w] takes tag_wr_i[w] and valid=1.
- Write-write conflict on the same address: the highest-numbered write port wins.
- Invalidate: inval_mask_i[e]=1 clears the valid bit of entry e. The stored tag is kept.
- Invalidate and write to the same entry in the same cycle: the write wins and the entry ends valid.
- flush_i=1: all valid bits clear and all writes that cycle are ignored. flush_i has priority over writes and inval_mask_i.
- reset=1: all tags clear to 0 and all valid bits to 0. match_o, hit_o and hit_idx_o clear to 0. All other inputs are ignored. reset has priority over flush_i.
- hit_idx_o: priority encode of the match vector, with the lowest index winning.
- When search_valid_i[p]=0, port p registers all zeros on the next edge.
- Out-of-range write addresses cannot occur because CAM_DEPTH = 2^CAM_INDEX is required. Instantiating with any other CAM_DEPTH is illegal.

## Timing
- Search latency is 1 cycle: a request presented in cycle N produces match_o, hit_o and hit_idx_o valid in cycle N+1, and they hold until the next edge.
- A search in cycle N compares against the entry state as defined in Configuration.
- Write, invalidate and flush take effect at the edge ending cycle N. The new state is visible to searches issued in cycle N+1 in all configurations.
- Reset asserted in cycle N: outputs read 0 in cycle N+1 and any search issued in cycle N is discarded. The first valid search result appears 1 cycle after the first search issued with reset low.
- Combinational path: compare, then priority encode, then the output register. There is no input-to-output combinational path.

## Configuration
- CAM_WR_BYPASS_EN defined:
  - A search in cycle N compares against the post-update state of that cycle, after writes, invalidates and flush are applied with the priorities above.
  - A tag written in cycle N therefore matches a search issued in cycle N.
  - An entry invalidated or flushed in cycle N does not match a search issued in cycle N.
- CAM_WR_BYPASS_EN undefined:
  - A search in cycle N compares against the registered state at the start of cycle N.
  - Same-cycle writes, invalidates and flush are not seen by that search.

## Test plan
- Reset, then search tag 0x00 on all ports -> match_o=0 and hit_o=0. This confirms that invalid zero-tagged entries do not match.
- Cycle 0: write tag 0x5A to entry 3 via port 0. Cycle 1: search 0x5A on port 2. -> In cycle 2, match vector port 2 = 0x0008, hit_o[2]=1, hit_idx=3.
- Same cycle: port 0 writes 0x11 and port 3 writes 0x22, both to entry 7. Next cycle, search both tags -> 0x22 hits at index 7 and 0x11 misses.
- Write 0x33 to entries 2 and 9. Then search 0x33 -> match vector = 0x0204 and hit_idx=2. Then pulse inval_mask_i=0x0004, search again -> match vector = 0x0200 and hit_idx=9.
- Same cycle as write 0x44 to entry 5, search 0x44 -> hit next cycle only with CAM_WR_BYPASS_EN. Also assert flush_i with a valid search -> the next cycle's search misses everywhere.
- Assert reset for one cycle between a search and its result -> outputs read 0 and the discarded result never appears.
